bus_rtc: RTL and testbench
==========================

BUS_RTC -- requirements
Module: bus_rtc

Interface
REQ-001 Parameter T_PULSO, default 4: cycles per strobe phase (address strobe, read/write strobe); legal range 1..255.
REQ-002 Parameter T_ESPERA, default 2: cycles per recovery phase after each strobe phase; legal range 1..255.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 activa  in  1  level request from the read/write controller; high = transaction requested.
REQ-006 w  in  1  transaction type: 1 = write, 0 = read.
REQ-007 dir  in  8  RTC register address.
REQ-008 dato_in  in  8  write data.
REQ-009 fin  out  1  one-cycle pulse marking transaction completion; feeds the controller's fin input.
REQ-010 dato_out  out  8  last byte read from the RTC.
REQ-011 ad  inout  8  multiplexed address/data bus to the RTC.
REQ-012 cs_n, ad_n, rd_n, wr_n  out  1 each  active-low chip select, address strobe, read strobe and write strobe.

Function
REQ-013 The block SHALL implement the states IDLE, ADDR, ESP1, DATO, ESP2, FIN and LIBERA, with a phase counter of at least 8 bits.
REQ-014 In IDLE, a sample of activa=1 SHALL latch dir, w and dato_in and move to ADDR on the same edge; changes on those inputs after that edge SHALL have no effect until the next acceptance.
REQ-015 All strobe outputs and fin SHALL be registered and SHALL take their new-state values on the edge that enters the state.
REQ-016 ADDR SHALL last T_PULSO cycles with cs_n=0, ad_n=0, rd_n=1, wr_n=1, and ad driven with the latched address.
REQ-017 ESP1 SHALL last T_ESPERA cycles with cs_n=0, all other strobes 1, and ad released (high-Z) on a read or driven with the latched data on a write.
REQ-018 DATO SHALL last T_PULSO cycles with cs_n=0, ad_n=1, and either wr_n=0 with ad driving the latched data (write) or rd_n=0 with ad high-Z (read).
REQ-019 On a read, dato_out SHALL capture ad on the edge that leaves DATO, while rd_n is still low.
REQ-020 On a write, dato_out SHALL hold its previous value.
REQ-021 ESP2 SHALL last T_ESPERA cycles with all strobes 1 and ad high-Z.
REQ-022 FIN SHALL last exactly one cycle with fin=1, then move to LIBERA.
REQ-023 LIBERA SHALL wait with fin=0 until activa=0 is sampled, then return to IDLE; activa held high SHALL NOT restart a transaction.
REQ-024 With activa sampled high at edge k, fin SHALL be high exactly during the cycle following edge k+2*T_PULSO+2*T_ESPERA (defaults: edge k+12).
REQ-025 ad SHALL be high-Z in every state except ADDR, ESP1-write and DATO-write; the block SHALL never drive ad while rd_n=0.
REQ-026 rd_n and wr_n SHALL never be low simultaneously, and neither SHALL be low while ad_n=0.
REQ-027 An unreachable state encoding SHALL return to IDLE on the next edge with all strobes high.

Reset
REQ-028 reset=0 SHALL immediately, without waiting for a clock edge, force state IDLE, counter 0, fin=0, dato_out=0x00, cs_n=ad_n=rd_n=wr_n=1 and ad high-Z.
REQ-029 Reset asserted mid-transaction SHALL abort it with no fin pulse.
REQ-030 After release, the block SHALL accept a request only on a clock edge at which reset=1 and activa=1.

Verification
REQ-031 Write: dir=0x21, dato_in=0x59, w=1, activa pulsed high -> ad=0x21 while ad_n=0 for 4 cycles; wr_n=0 for 4 cycles with ad=0x59; fin high 12 cycles after acceptance; dato_out unchanged.
REQ-032 Read: dir=0x22, w=0, RTC model drives 0xA5 while rd_n=0 -> rd_n low 4 cycles, ad released by the block, dato_out=0xA5 after DATO, single fin pulse.
REQ-033 activa held high for 20 cycles after fin -> no second ADDR phase; drop activa for one cycle and raise it again -> a new transaction starts.
REQ-034 dir and dato_in changed to 0xFF during ESP1 -> bus still shows the originally latched 0x21 and 0x59.
REQ-035 reset driven low in the middle of DATO -> strobes high and ad high-Z before the next clock edge, no fin pulse, dato_out=0x00.
REQ-036 T_PULSO=1, T_ESPERA=1 -> fin high 4 cycles after acceptance, and REQ-025 and REQ-026 hold throughout.

Source files
------------

// File: rtl/bus_rtc.sv
// Bus sequencer for a multiplexed address/data RTC (Intel-style AD bus).
// One transaction per accepted request: address strobe phase, recovery,
// read or write strobe phase, recovery, a one-cycle fin pulse, then a wait
// for the requester to drop activa.
//
// Ports:
//   clk       sole clock, rising edge
//   reset     asynchronous, active-low reset
//   activa    level request; sampled in IDLE (start) and LIBERA (release)
//   w         1 = write, 0 = read (latched on acceptance)
//   dir       RTC register address (latched on acceptance)
//   dato_in   write data (latched on acceptance)
//   fin       one-cycle completion pulse
//   dato_out  last byte read from the RTC
//   ad        multiplexed address/data bus, high-Z when not driven
//   cs_n, ad_n, rd_n, wr_n  active-low chip select and strobes (registered)
module bus_rtc #(
  parameter int unsigned T_PULSO  = 4,
  parameter int unsigned T_ESPERA = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       activa,
  input  logic       w,
  input  logic [7:0] dir,
  input  logic [7:0] dato_in,
  output logic       fin,
  output logic [7:0] dato_out,
  inout  wire  [7:0] ad,
  output logic       cs_n,
  output logic       ad_n,
  output logic       rd_n,
  output logic       wr_n
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StAddr   = 3'd1,
    StEsp1   = 3'd2,
    StDato   = 3'd3,
    StEsp2   = 3'd4,
    StFin    = 3'd5,
    StLibera = 3'd6
  } state_e;

  localparam logic [7:0] PulsoLast  = 8'(T_PULSO - 1);
  localparam logic [7:0] EsperaLast = 8'(T_ESPERA - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] dir_q, dir_d;
  logic [7:0] dato_q, dato_d;
  logic       w_q, w_d;
  logic [7:0] dato_out_q, dato_out_d;

  logic       fin_q, fin_d;
  logic       cs_n_q, cs_n_d;
  logic       ad_n_q, ad_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       ad_oe_q, ad_oe_d;
  logic [7:0] ad_val_q, ad_val_d;

  // State register (also holds the registered outputs).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= 8'h00;
      dir_q      <= 8'h00;
      dato_q     <= 8'h00;
      w_q        <= 1'b0;
      dato_out_q <= 8'h00;
      fin_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      ad_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      ad_oe_q    <= 1'b0;
      ad_val_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      dato_q     <= dato_d;
      w_q        <= w_d;
      dato_out_q <= dato_out_d;
      fin_q      <= fin_d;
      cs_n_q     <= cs_n_d;
      ad_n_q     <= ad_n_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      ad_oe_q    <= ad_oe_d;
      ad_val_q   <= ad_val_d;
    end
  end

  // Next-state logic: each timed phase counts 0..last, then advances.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    dato_d     = dato_q;
    w_d        = w_q;
    dato_out_d = dato_out_q;
    case (state_q)
      StIdle: begin
        cnt_d = 8'h00;
        if (activa) begin
          dir_d   = dir;
          dato_d  = dato_in;
          w_d     = w;
          state_d = StAddr;
        end
      end
      StAddr, StDato: begin
        if (cnt_q == PulsoLast) begin
          cnt_d   = 8'h00;
          state_d = (state_q == StAddr) ? StEsp1 : StEsp2;
          // Capture while rd_n is still low, before the RTC lets go of the bus.
          if (state_q == StDato && !w_q) dato_out_d = ad;
        end else begin
          cnt_d = cnt_q + 8'h01;
        end
      end
      StEsp1, StEsp2: begin
        if (cnt_q == EsperaLast) begin
          cnt_d   = 8'h00;
          state_d = (state_q == StEsp1) ? StDato : StFin;
        end else begin
          cnt_d = cnt_q + 8'h01;
        end
      end
      StFin: state_d = StLibera;
      StLibera: begin
        if (!activa) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'h00;
      end
    endcase
  end

  // Output decode from the state being entered, so the registered outputs
  // change on the same edge as the state.
  always_comb begin
    fin_d    = 1'b0;
    cs_n_d   = 1'b1;
    ad_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    ad_oe_d  = 1'b0;
    ad_val_d = 8'h00;
    case (state_d)
      StAddr: begin
        cs_n_d   = 1'b0;
        ad_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_val_d = dir_d;
      end
      StEsp1: begin
        cs_n_d   = 1'b0;
        ad_oe_d  = w_d;
        ad_val_d = dato_d;
      end
      StDato: begin
        cs_n_d   = 1'b0;
        wr_n_d   = ~w_d;
        rd_n_d   = w_d;
        ad_oe_d  = w_d;
        ad_val_d = dato_d;
      end
      StFin:   fin_d = 1'b1;
      default: ;
    endcase
  end

  assign ad       = ad_oe_q ? ad_val_q : 8'bz;
  assign fin      = fin_q;
  assign dato_out = dato_out_q;
  assign cs_n     = cs_n_q;
  assign ad_n     = ad_n_q;
  assign rd_n     = rd_n_q;
  assign wr_n     = wr_n_q;

endmodule

// File: tb/tb_bus_rtc.sv
// Bench for bus_rtc: two instances (default timing and T_PULSO=T_ESPERA=1)
// checked cycle by cycle against a phase model derived from the elapsed
// cycles since acceptance.
module tb_bus_rtc;

  localparam int PhAddr   = 0;
  localparam int PhEsp1   = 1;
  localparam int PhDato   = 2;
  localparam int PhEsp2   = 3;
  localparam int PhFin    = 4;
  localparam int PhLibera = 5;

  logic       clk = 1'b0;
  logic       reset, activa, w, sel;
  logic [7:0] dir, dato_in;
  wire  [7:0] ad_a, ad_b;
  logic       fin_a, cs_n_a, ad_n_a, rd_n_a, wr_n_a;
  logic       fin_b, cs_n_b, ad_n_b, rd_n_b, wr_n_b;
  logic [7:0] dato_out_a, dato_out_b;

  // RTC / bus-keeper side: drives the bus only where the block must release it.
  logic       drv_en;
  logic [7:0] drv_val;

  int         n_cmp, n_err;
  logic [7:0] exp_dato [2];

  always #5 clk = ~clk;

  assign ad_a = (drv_en && !sel) ? drv_val : 8'bz;
  assign ad_b = (drv_en &&  sel) ? drv_val : 8'bz;

  bus_rtc #(.T_PULSO(4), .T_ESPERA(2)) u_dut_a (
    .clk(clk), .reset(reset), .activa(activa && !sel), .w(w), .dir(dir),
    .dato_in(dato_in), .fin(fin_a), .dato_out(dato_out_a), .ad(ad_a),
    .cs_n(cs_n_a), .ad_n(ad_n_a), .rd_n(rd_n_a), .wr_n(wr_n_a)
  );

  bus_rtc #(.T_PULSO(1), .T_ESPERA(1)) u_dut_b (
    .clk(clk), .reset(reset), .activa(activa && sel), .w(w), .dir(dir),
    .dato_in(dato_in), .fin(fin_b), .dato_out(dato_out_b), .ad(ad_b),
    .cs_n(cs_n_b), .ad_n(ad_n_b), .rd_n(rd_n_b), .wr_n(wr_n_b)
  );

  logic [4:0] pins_o;
  logic [7:0] ad_o, dato_o;
  assign pins_o = sel ? {cs_n_b, ad_n_b, rd_n_b, wr_n_b, fin_b}
                      : {cs_n_a, ad_n_a, rd_n_a, wr_n_a, fin_a};
  assign ad_o   = sel ? ad_b : ad_a;
  assign dato_o = sel ? dato_out_b : dato_out_a;

  function automatic int plen();
    return sel ? 1 : 4;
  endfunction

  function automatic int elen();
    return sel ? 1 : 2;
  endfunction

  // Phase occupied during the cycle after edge k+off (acceptance at edge k).
  function automatic int phase_of(input int off, input int p, input int e);
    if (off < p)               return PhAddr;
    if (off < p + e)           return PhEsp1;
    if (off < 2 * p + e)       return PhDato;
    if (off < 2 * p + 2 * e)   return PhEsp2;
    if (off == 2 * p + 2 * e)  return PhFin;
    return PhLibera;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, sel, obs, exp_v);
    end
  endtask

  // Pin vector order: {cs_n, ad_n, rd_n, wr_n, fin}.
  task automatic txn(input bit wr, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] rtc, input bit mid, input bit hold,
                     input int abort_off);
    int p, e, tot, ph;
    logic [4:0] pins_exp;
    logic [7:0] bus_exp;
    p   = plen();
    e   = elen();
    tot = 2 * p + 2 * e;
    dir = a; dato_in = d; w = wr; activa = 1'b1; drv_en = 1'b0;
    for (int off = 0; off <= tot + 1; off++) begin
      @(posedge clk); #1;
      if (off == 0 && !hold) activa = 1'b0;
      ph = phase_of(off, p, e);
      if (off == abort_off) begin
        drv_en  = 1'b1;
        drv_val = 8'($urandom);
        #2 reset = 1'b0;
        #1;
        exp_dato[0] = 8'h00;
        exp_dato[1] = 8'h00;
        chk("abort_pins", 32'(pins_o), 32'(5'b11110));
        chk("abort_dato_out", 32'(dato_o), 32'(exp_dato[sel]));
        chk("abort_ad_released", 32'(ad_o), 32'(drv_val));
        return;
      end
      drv_en  = !(ph == PhAddr || (wr && (ph == PhEsp1 || ph == PhDato)));
      drv_val = (ph == PhDato && !wr) ? rtc : 8'($urandom);
      if (mid && off == p) begin
        dir     = 8'hff;
        dato_in = 8'hff;
      end
      if (!wr && off == 2 * p + e) exp_dato[sel] = rtc;
      @(negedge clk);
      bus_exp = drv_val;
      case (ph)
        PhAddr: begin pins_exp = 5'b00110; bus_exp = a; end
        PhEsp1: begin pins_exp = 5'b01110; if (wr) bus_exp = d; end
        PhDato: begin
          pins_exp = wr ? 5'b01100 : 5'b01010;
          if (wr) bus_exp = d;
        end
        PhFin:   pins_exp = 5'b11111;
        default: pins_exp = 5'b11110;
      endcase
      chk($sformatf("pins_off%0d", off), 32'(pins_o), 32'(pins_exp));
      chk($sformatf("ad_off%0d", off), 32'(ad_o), 32'(bus_exp));
      chk($sformatf("dato_out_off%0d", off), 32'(dato_o), 32'(exp_dato[sel]));
    end
    if (hold) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        chk("hold_no_restart", 32'(pins_o), 32'(5'b11110));
      end
    end
    activa = 1'b0;
    @(posedge clk); #1;
    drv_en = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    sel = 1'b0; reset = 1'b0; activa = 1'b0; w = 1'b0;
    dir = 8'h00; dato_in = 8'h00; drv_en = 1'b0; drv_val = 8'h00;
    exp_dato[0] = 8'h00; exp_dato[1] = 8'h00;

    #12;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("reset_pins", 32'(pins_o), 32'(5'b11110));
      chk("reset_dato_out", 32'(dato_o), 32'h00);
    end
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Default timing instance.
    txn(1'b1, 8'h21, 8'h59, 8'h00, 1'b0, 1'b0, -1);
    txn(1'b0, 8'h22, 8'h00, 8'ha5, 1'b0, 1'b0, -1);
    txn(1'b1, 8'h21, 8'h59, 8'h00, 1'b1, 1'b0, -1);
    txn(1'b0, 8'h0c, 8'h00, 8'h3c, 1'b0, 1'b1, -1);
    txn(1'b1, 8'h0d, 8'h77, 8'h00, 1'b0, 1'b0, -1);
    for (int i = 0; i < 6; i++)
      txn(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, -1);

    // Abort in the middle of a read DATO phase.
    txn(1'b0, 8'h33, 8'h00, 8'h5a, 1'b0, 1'b0, 7);
    activa = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("in_reset_pins", 32'(pins_o), 32'(5'b11110));
    end
    #2 reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("post_abort_no_fin", 32'(pins_o), 32'(5'b11110));
      chk("post_abort_dato_out", 32'(dato_o), 32'h00);
    end
    txn(1'b0, 8'h44, 8'h00, 8'hc3, 1'b0, 1'b0, -1);

    // Minimum timing instance.
    sel = 1'b1;
    txn(1'b1, 8'h21, 8'h59, 8'h00, 1'b0, 1'b0, -1);
    txn(1'b0, 8'h22, 8'h00, 8'ha5, 1'b0, 1'b0, -1);
    txn(1'b0, 8'h01, 8'h00, 8'h96, 1'b0, 1'b1, -1);
    for (int i = 0; i < 8; i++)
      txn(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
